// File: rtl/adder_sweep_ctrl.sv
// Sweep controller that walks 4-bit operand pairs into an external adder and counts wrong sums.
// Define ADDER_SWEEP_LFSR_EN to source vectors from an 8-bit LFSR instead of the counting order.
module adder_sweep_ctrl #(
  parameter int NUM_VEC    = 256,
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [4:0] sum_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  localparam logic [7:0] LAST_IDX  = 8'(NUM_VEC - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state_reg, state_next;
  logic [7:0] idx_reg, idx_next;
  logic [3:0] wait_reg, wait_next;
  logic [3:0] a_reg, a_next;
  logic [3:0] b_reg, b_next;
  logic [7:0] err_reg, err_next;
  logic [7:0] vec;
  logic       mismatch;

  assign mismatch = (sum_in != ({1'b0, a_reg} + {1'b0, b_reg}));

`ifdef ADDER_SWEEP_LFSR_EN
  logic [7:0] lfsr_reg, lfsr_next;
  logic       lfsr_fb;

  // Fibonacci taps 8,6,5,4: maximal length, so 255 vectors visit every nonzero byte once
  assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign vec     = lfsr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_reg <= 8'h01;
    else      lfsr_reg <= lfsr_next;
  end
`else
  assign vec = idx_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= 8'd0;
      wait_reg  <= 4'd0;
      a_reg     <= 4'd0;
      b_reg     <= 4'd0;
      err_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      wait_reg  <= wait_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    err_next   = err_reg;
`ifdef ADDER_SWEEP_LFSR_EN
    lfsr_next  = lfsr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = DRIVE;
          idx_next   = 8'd0;
          err_next   = 8'd0;
`ifdef ADDER_SWEEP_LFSR_EN
          lfsr_next  = 8'h01;
`endif
        end
      end
      DRIVE: begin
        a_next     = vec[7:4];
        b_next     = vec[3:0];
        wait_next  = WAIT_LOAD;
        state_next = WAIT;
      end
      WAIT: begin
        // counter loaded with SETTLE_CYC-1 so WAIT lasts exactly SETTLE_CYC cycles
        if (wait_reg == 4'd0) state_next = CHECK;
        else                  wait_next  = wait_reg - 4'd1;
      end
      CHECK: begin
        if (mismatch && (err_reg != 8'hFF)) err_next = err_reg + 8'd1;
`ifdef ADDER_SWEEP_LFSR_EN
        lfsr_next = {lfsr_reg[6:0], lfsr_fb};
`endif
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = DRIVE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign A       = a_reg;
  assign B       = b_reg;
  assign err_cnt = err_reg;
  assign busy    = (state_reg == DRIVE) || (state_reg == WAIT) || (state_reg == CHECK);
  assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Self-checking bench for adder_sweep_ctrl: faulty-adder models, reset abort and held-start sweeps.
// Build with ADDER_SWEEP_LFSR_EN defined to exercise the LFSR vector order (NUM_VEC=255).
module tb_adder_sweep_ctrl;

`ifdef ADDER_SWEEP_LFSR_EN
  localparam int NV = 255;
`else
  localparam int NV = 256;
`endif
  localparam int SC  = 1;
  localparam int LAT = NV * (SC + 2);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A, B;
  logic [4:0] sum_in;
  logic       busy, done;
  logic [7:0] err_cnt;

  int         mode = 0;
  logic [4:0] fault_mask [256];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  adder_sweep_ctrl #(.NUM_VEC(NV), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .sum_in(sum_in), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  // Adder under control: 0 correct, 1 bit0 stuck low, 2 sum+1, 3 random per-vector corruption
  function automatic logic [4:0] model_sum(input int m, input logic [7:0] v);
    logic [4:0] t;
    t = {1'b0, v[7:4]} + {1'b0, v[3:0]};
    case (m)
      0:       return t;
      1:       return t & 5'h1E;
      2:       return t + 5'd1;
      default: return t ^ fault_mask[v];
    endcase
  endfunction

  assign sum_in = model_sum(mode, {A, B});

  // Expected error count: order-independent, so only the set of vectors in a sweep matters
  function automatic int model_err(input int m);
    int cnt;
    logic [7:0] v;
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      v = 8'(k);
`ifdef ADDER_SWEEP_LFSR_EN
      if (k == 0) continue;
`else
      if (k >= NV) continue;
`endif
      if (model_sum(m, v) != ({1'b0, v[7:4]} + {1'b0, v[3:0]})) cnt++;
    end
    return (cnt > 255) ? 255 : cnt;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge of the first DRIVE cycle; returns at the negedge after DONE
  task automatic count_sweep(input int exp_err, input string name);
    int cyc, walk_bad, k, first_v;
    logic [7:0] v;
    bit seen [256];
    cyc = 0; walk_bad = 0; first_v = -1;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    check({name, " start accepted"}, int'(busy), 1);
    while (busy && cyc < LAT + 50) begin
      if (cyc % (SC + 2) == SC + 1) begin
        v = {A, B};
        k = cyc / (SC + 2);
`ifdef ADDER_SWEEP_LFSR_EN
        if (k == 0) first_v = int'(v);
        if (v == 8'h00 || seen[v]) walk_bad++;
        seen[v] = 1'b1;
`else
        if (v != 8'(k)) walk_bad++;
`endif
      end
      cyc++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, cyc, LAT);
    check({name, " vector walk errors"}, walk_bad, 0);
`ifdef ADDER_SWEEP_LFSR_EN
    check({name, " first vector"}, first_v, 1);
`endif
    check({name, " done at end"}, int'(done), 1);
    check({name, " err_cnt"}, int'(err_cnt), exp_err);
    $display("sweep %s: busy cycles=%0d err_cnt=%0d expected=%0d", name, cyc, err_cnt, exp_err);
    @(negedge clk);
    check({name, " done one cycle"}, int'(done), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    int    mode;
    string name;
    int    exp_err;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int done_seen;
    for (int v = 0; v < 256; v++)
      fault_mask[v] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    tbl[0] = '{0, "correct",   model_err(0)};
    tbl[1] = '{1, "lsb_stuck", model_err(1)};
    tbl[2] = '{2, "plus_one",  model_err(2)};
    tbl[3] = '{3, "random",    model_err(3)};

    // reset state
    repeat (3) @(negedge clk);
    check("reset AB", int'({A, B}), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err_cnt", int'(err_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      pulse_start();
      count_sweep(tbl[i].exp_err, tbl[i].name);
    end
    repeat (4) @(negedge clk);
    check("err_cnt holds in idle", int'(err_cnt), tbl[3].exp_err);
    check("idle not busy", int'(busy), 0);

    // asynchronous reset partway through a sweep
    mode = 2;
    pulse_start();
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort AB", int'({A, B}), 0);
    check("abort busy", int'(busy), 0);
    check("abort err_cnt", int'(err_cnt), 0);
    check("abort done", int'(done), 0);
    start = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("no activity in reset", done_seen, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mode = 0;
    pulse_start();
    count_sweep(model_err(0), "after_reset");

    // start held high: one sweep per IDLE visit, next sweep right after IDLE
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    count_sweep(model_err(1), "held_1");
    check("held idle gap", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    count_sweep(model_err(1), "held_2");
    repeat (3) @(negedge clk);
    check("no queued sweep", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_sweep_ctrl.md
ADDER_SWEEP_CTRL -- requirements
Module: adder_sweep_ctrl

Interface
REQ-001 SHALL have parameter NUM_VEC, default 256, meaning number of operand vectors per sweep (legal 1..256).
REQ-002 SHALL have parameter SETTLE_CYC, default 1, meaning wait cycles between operand launch and result sampling (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  sweep request, sampled in IDLE only.
REQ-006 SHALL have port A  output  4  operand A driven to the adder under control.
REQ-007 SHALL have port B  output  4  operand B driven to the adder under control.
REQ-008 SHALL have port sum_in  input  5  adder result, carry-out in bit 4.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-011 SHALL have port err_cnt  output  8  mismatch count of the last or current sweep.

Function
REQ-012 SHALL implement states IDLE, DRIVE, WAIT, CHECK, DONE as a registered FSM.
REQ-013 IDLE: start=1 -> DRIVE; clears err_cnt and vector index idx (8 bit) to 0; start=0 -> stay.
REQ-014 DRIVE: registers A and B from the current vector (REQ-021/022); -> WAIT next cycle.
REQ-015 WAIT: holds A/B for exactly SETTLE_CYC cycles, via a 4-bit down-counter; -> CHECK.
REQ-016 CHECK: compares sum_in against 5-bit {1'b0,A}+{1'b0,B}; mismatch increments err_cnt, saturating at 255.
REQ-017 CHECK: idx==NUM_VEC-1 -> DONE; otherwise idx+1 -> DRIVE.
REQ-018 DONE: done=1 for one cycle, busy=0; -> IDLE; err_cnt, A, B hold until the next accepted start.
REQ-019 Sweep latency SHALL be NUM_VEC*(SETTLE_CYC+2) cycles from the first DRIVE cycle to the DONE cycle inclusive of the final CHECK.
REQ-020 start asserted while busy or in DONE SHALL be ignored; no queuing.
REQ-021 Default vector generation: A=idx[7:4], B=idx[3:0]; idx wraps are impossible since a sweep ends at NUM_VEC-1.

Reset
REQ-022 rst low SHALL immediately force IDLE, A=0, B=0, busy=0, done=0, err_cnt=0, idx=0, wait counter=0, regardless of clk.
REQ-023 Reset mid-sweep SHALL abort the sweep with no done pulse; first start after rst release begins a fresh sweep.

Configuration
REQ-024 Macro ADDER_SWEEP_LFSR_EN defined: vectors SHALL come from an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'h01 on accepted start, advanced in each CHECK; A=lfsr[7:4], B=lfsr[3:0]; idx still counts vectors; NUM_VEC above 255 repeats the seed vector.
REQ-025 Macro undefined: REQ-021 counting order SHALL apply and no LFSR logic SHALL be synthesised.

Verification
REQ-026 Correct adder model, defaults, start pulse -> A/B walk 00..FF, done after 768 cycles of busy, err_cnt=0.
REQ-027 Model with sum_in[0] stuck at 0 -> err_cnt=128 at done.
REQ-028 Model returning true sum+1 -> err_cnt saturates at 255, done still pulses once.
REQ-029 rst low during cycle 100 of a sweep -> A=0, B=0, busy=0, err_cnt=0 asynchronously, no done; restart gives full 768-cycle sweep.
REQ-030 start held high through a sweep -> exactly one sweep per IDLE visit, new sweep begins the cycle after DONE.
REQ-031 ADDER_SWEEP_LFSR_EN defined, NUM_VEC=255 -> first vector A=0,B=1, all 255 nonzero {A,B} appear once, 00 never driven.
